// File: rtl/seven_seg_scan.sv
// seven_seg_scan: four-digit multiplexed decimal display driver.
// A 14-bit binary value is captured, clamped to 9999, converted to BCD by an
// iterative double-dabble engine and committed to the display register in one
// step. A free-running refresh counter scans the four positions, and optional
// leading-zero blanking replaces leading zeros with 4'hF.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready=1; a load captures value and starts a conversion
// CONV  | ready=0; 14 shift steps, then commit to display on the 15th edge
module seven_seg_scan #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        load,
    input  logic        lzb,
    output logic        ready,
    output logic        ovf,
    output logic [3:0]  digit,
    output logic [1:0]  position
);

    localparam int unsigned     CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [13:0]     MAX_VAL   = 14'd9999;
    localparam logic [3:0]      LAST_STEP = 4'd14;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t           state_q;
    logic [29:0]      shift_q;     // {bcd[15:0], bin[13:0]}
    logic [29:0]      shift_d;
    logic [3:0]       step_q;
    logic             pend_ovf_q;
    logic [15:0]      disp_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       pos_q;

    logic             over_d;
    logic [13:0]      clamp_d;

    logic [3:0]       d0, d1, d2, d3;
    logic             z1, z2, z3;

    // Clamp the incoming value so the conversion never needs a fifth digit.
    always_comb begin
        over_d  = (value > MAX_VAL);
        clamp_d = over_d ? MAX_VAL : value;
    end

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        logic [29:0] adj;
        adj = shift_q;
        for (int i = 0; i < 4; i++) begin
            if (adj[14 + 4*i +: 4] >= 4'd5) begin
                adj[14 + 4*i +: 4] = adj[14 + 4*i +: 4] + 4'd3;
            end
        end
        shift_d = {adj[28:0], 1'b0};
    end

    // Conversion FSM; the display register is only written on the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            step_q     <= '0;
            pend_ovf_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q    <= CONV;
                        shift_q    <= {16'd0, clamp_d};
                        step_q     <= '0;
                        pend_ovf_q <= over_d;
                    end
                end
                CONV: begin
                    if (step_q == LAST_STEP) begin
                        state_q <= IDLE;
                        disp_q  <= shift_q[29:14];
                        ovf_q   <= pend_ovf_q;
                    end else begin
                        shift_q <= shift_d;
                        step_q  <= step_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Refresh counter and scan position; independent of the conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            pos_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            pos_q <= pos_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Digit select with leading-zero blanking from the committed digits only.
    always_comb begin
        d0 = disp_q[3:0];
        d1 = disp_q[7:4];
        d2 = disp_q[11:8];
        d3 = disp_q[15:12];
        z3 = (d3 == 4'd0);
        z2 = z3 && (d2 == 4'd0);
        z1 = z2 && (d1 == 4'd0);
        digit = d0;
        case (pos_q)
            2'd0:    digit = d0;
            2'd1:    digit = (lzb && z1) ? 4'hF : d1;
            2'd2:    digit = (lzb && z2) ? 4'hF : d2;
            2'd3:    digit = (lzb && z3) ? 4'hF : d3;
            default: digit = d0;
        endcase
    end

    assign ready    = (state_q == IDLE);
    assign ovf      = ovf_q;
    assign position = pos_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan: directed scenarios on a REFRESH_DIV=4 instance
// plus four REFRESH_DIV=2 instances that sweep 0..9999 in parallel lanes.
module tb_seven_seg_scan;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic        lzb;
    logic        ready;
    logic        ovf;
    logic [3:0]  digit;
    logic [1:0]  position;

    logic        rst_sw;
    logic [13:0] sw_value [4];
    logic        sw_load  [4];
    logic        sw_ready [4];
    logic        sw_ovf   [4];
    logic [3:0]  sw_digit [4];
    logic [1:0]  sw_pos   [4];
    logic        sw_lzb;

    int n_assert = 0;
    int n_fail   = 0;
    int edges    = 0;

    logic [16:0] sb[$];

    seven_seg_scan #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .lzb(lzb),
        .ready(ready), .ovf(ovf), .digit(digit), .position(position)
    );

    for (genvar g = 0; g < 4; g++) begin : g_lane
        seven_seg_scan #(.REFRESH_DIV(2)) dut_sw (
            .clk(clk), .rst(rst_sw), .value(sw_value[g]), .load(sw_load[g]),
            .lzb(sw_lzb), .ready(sw_ready[g]), .ovf(sw_ovf[g]),
            .digit(sw_digit[g]), .position(sw_pos[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference edge count since reset release, used to predict position.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [3:0] exp_digit(input logic [15:0] b, input int p, input logic lz);
        logic [3:0] d[4];
        logic blank;
        for (int i = 0; i < 4; i++) d[i] = b[4*i +: 4];
        if (lz && p > 0) begin
            blank = 1'b1;
            for (int i = p; i < 4; i++) if (d[i] != 4'd0) blank = 1'b0;
            if (blank) return 4'hF;
        end
        return d[p];
    endfunction

    task automatic do_load(input int v, input bit push);
        value = 14'(v);
        load  = 1'b1;
        if (push) sb.push_back({(v > 9999) ? 1'b1 : 1'b0, to_bcd(v)});
        @(negedge clk);
        load = 1'b0;
        check("load_accept_ready", ready, 1'b0);
    endtask

    task automatic wait_commit(input string tag, input int exp_cnt);
        int cnt;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_busy_edges"}, cnt, exp_cnt);
    endtask

    task automatic check_display(input string tag, input logic lz);
        logic [16:0] e;
        int p;
        check({tag, "_sb_nonempty"}, (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_ovf"}, ovf, e[16]);
        for (int s = 0; s < 16; s++) begin
            p = (edges / 4) % 4;
            check({tag, "_pos"}, position, p);
            check({tag, "_digit"}, digit, exp_digit(e[15:0], p, lz));
            @(negedge clk);
        end
    endtask

    task automatic sweep_lane(input int lane);
        logic [15:0] q[$];
        logic [3:0]  got[4];
        logic [15:0] exp_b;
        int wcnt;
        int v;
        for (int n = 0; n <= 2500; n++) begin
            wcnt = 0;
            while (sw_ready[lane] !== 1'b1 && wcnt < 40) begin
                @(negedge clk);
                wcnt++;
            end
            check("sweep_ready", sw_ready[lane], 1'b1);
            if (n < 2500) begin
                v = lane * 2500 + n;
                sw_value[lane] = 14'(v);
                sw_load[lane]  = 1'b1;
                q.push_back(to_bcd(v));
            end else begin
                sw_load[lane] = 1'b0;
            end
            for (int i = 0; i < 4; i++) got[i] = 4'hx;
            for (int s = 0; s < 8; s++) begin
                @(negedge clk);
                got[sw_pos[lane]] = sw_digit[lane];
            end
            if (n > 0) begin
                exp_b = q.pop_front();
                check("sweep_bcd", {got[3], got[2], got[1], got[0]}, exp_b);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        rst_sw = 1'b1;
        load   = 1'b0;
        value  = '0;
        lzb    = 1'b0;
        sw_lzb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sw_load[i]  = 1'b0;
            sw_value[i] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_position", position, 2'd0);
        check("rst_digit", digit, 4'd0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("first_adv_before", position, 2'd0);
        @(negedge clk);
        check("first_adv_at", position, 2'd1);

        // 1234, lzb=0: 15 busy edges, then digits 4,3,2,1
        do_load(1234, 1'b1);
        wait_commit("conv_1234", 15);
        check_display("disp_1234", 1'b0);

        // Overflow clamp and clear
        do_load(12000, 1'b1);
        wait_commit("conv_12000", 15);
        check_display("disp_12000", 1'b0);
        do_load(5, 1'b1);
        wait_commit("conv_5", 15);
        check_display("disp_5", 1'b0);
        do_load(12000, 1'b1);
        wait_commit("conv_12000b", 15);
        check_display("disp_12000b", 1'b0);

        // Reset mid-conversion: abort, no commit, immediate effect
        do_load(8888, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ready", ready, 1'b1);
        check("async_rst_position", position, 2'd0);
        check("async_rst_digit", digit, 4'd0);
        check("async_rst_ovf", ovf, 1'b0);
        @(negedge clk);
        check("rst_held_ready", ready, 1'b1);
        check("rst_held_position", position, 2'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_adv_before", position, 2'd0);
        @(negedge clk);
        check("rst_adv_at", position, 2'd1);
        sb.push_back({1'b0, 16'h0000});
        check_display("disp_after_rst", 1'b0);

        // Leading-zero blanking
        lzb = 1'b1;
        do_load(7, 1'b1);
        wait_commit("conv_7", 15);
        check_display("lzb_7", 1'b1);
        do_load(0, 1'b1);
        wait_commit("conv_0", 15);
        check_display("lzb_0", 1'b1);
        do_load(305, 1'b1);
        wait_commit("conv_305", 15);
        check_display("lzb_305", 1'b1);
        lzb = 1'b0;
        check_display_no_pop: begin
            sb.push_back({1'b0, to_bcd(305)});
            check_display("nolzb_305", 1'b0);
        end

        // Load pulse during CONV is ignored
        do_load(42, 1'b1);
        repeat (4) @(negedge clk);
        value = 14'd99;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("ignored_load_busy", ready, 1'b0);
        wait_commit("conv_42", 10);
        check_display("disp_42", 1'b0);
        check("no_queued_conv", ready, 1'b1);
        check("sb_drained", sb.size(), 0);

        // Exhaustive sweep 0..9999 across four lanes with load held high
        @(negedge clk);
        rst_sw = 1'b0;
        @(negedge clk);
        fork
            sweep_lane(0);
            sweep_lane(1);
            sweep_lane(2);
            sweep_lane(3);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clk cycles each digit position stays active; legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port value, input, 14 bits: unsigned binary number to display.
REQ-005 SHALL have port load, input, 1 bit: request to capture value; acted on only while ready=1.
REQ-006 SHALL have port lzb, input, 1 bit: leading-zero blanking enable; sampled continuously.
REQ-007 SHALL have port ready, output, 1 bit: high when idle and able to accept load.
REQ-008 SHALL have port ovf, output, 1 bit: last committed value exceeded 9999.
REQ-009 SHALL have port digit, output, 4 bits: BCD digit for the active position, or 4'hF when the position is blanked.
REQ-010 SHALL have port position, output, 2 bits: active display position; 0 = least significant digit, 3 = most significant.

Function
REQ-011 SHALL hold a 4x4-bit display register (d3..d0) that drives digit; a new number never appears partially converted.
REQ-012 SHALL contain a refresh counter that counts 0..REFRESH_DIV-1 and wraps to 0.
REQ-013 SHALL advance position by 1 on the edge where the counter wraps; position 3 SHALL wrap to 0.
REQ-014 SHALL drive digit and position combinationally from the display register and the position register, with no added latency.
REQ-015 SHALL run a two-state FSM: IDLE (ready=1) and CONV (ready=0).
REQ-016 IDLE -> CONV: on an edge where load=1. value SHALL be captured on that edge, called edge k.
REQ-017 Capture clamp: a captured value greater than 9999 SHALL be replaced by 9999 and a pending-overflow bit set; otherwise the pending-overflow bit is cleared.
REQ-018 CONV SHALL perform the iterative double-dabble conversion, one shift step per edge, on edges k+1 through k+14.
REQ-019 Each shift step SHALL first add 3 to every BCD nibble >= 5, then shift left by 1.
REQ-020 On edge k+15 the FSM SHALL return to IDLE, and d3..d0 and ovf SHALL be updated from the result and the pending-overflow bit on that same edge.
REQ-021 ready SHALL be low from edge k through edge k+14 inclusive, and high again after edge k+15.
REQ-022 load asserted while ready=0 SHALL be ignored, neither queued nor stored.
REQ-023 load held high continuously SHALL start a new conversion on the first edge ready is seen high (edge k+15 of the previous conversion is not that edge).
REQ-024 During CONV, the display register, digit scanning and the refresh counter SHALL continue unaffected, showing the previous number.
REQ-025 Blanking: when lzb=1, a position p>0 SHALL output digit=4'hF if d[p] and all higher digits are 0; position 0 is never blanked.
REQ-026 When lzb=0, all four positions SHALL output their BCD value.
REQ-027 Blanking SHALL be evaluated from the committed display register only.

Reset
REQ-028 While rst=1, SHALL force: state=IDLE, ready=1, refresh counter=0, position=0, d3..d0=0, ovf=0, pending-overflow=0, and the conversion shift register cleared.
REQ-029 rst asserted mid-conversion SHALL abort the conversion with no commit; the display SHALL show 0000.
REQ-030 After rst deasserts, the first position advance SHALL occur REFRESH_DIV edges later.

Verification
REQ-031 Bench SHALL cover: REFRESH_DIV=4, load value=1234, lzb=0 -> ready low for 15 edges; afterwards position cycles 0,1,2,3 every 4 clk with digit 4,3,2,1.
REQ-032 Bench SHALL cover: load value=12000 -> after commit d3..d0=9,9,9,9 and ovf=1; then load 5 -> ovf=0.
REQ-033 Bench SHALL cover: lzb=1, value=7 -> position 0 digit=7, positions 1..3 digit=4'hF; value=0 -> position 0 digit=0, others 4'hF.
REQ-034 Bench SHALL cover: load 42, then pulse load with value=99 at edge k+5 -> pulse ignored; display commits 0042 only.
REQ-035 Bench SHALL cover: load 8888, then rst asserted at edge k+7 -> ready=1, display 0000, position=0 immediately (asynchronous).
REQ-036 Bench SHALL cover an exhaustive sweep of value 0..9999 -> committed BCD equals the decimal digits of value in every case.
